// File: rtl/oiia_pkg.sv
// oiia_pkg: shared definitions for the multi-byte add/subtract sequencer.
//   BYTE_W     - width of one operand/result byte and of the shared adder
//   NBYTES_MAX - largest supported operand width in bytes
//   state_e    - sequencer states
package oiia_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned NBYTES_MAX = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ADD,
        EMIT
    } state_e;

endpackage

// File: rtl/oiia_add8.sv
// oiia_add8: purely combinational 8-bit adder with carry in/out.
//   a, b  in  operand bytes
//   cin   in  carry in
//   sum   out low 8 bits of a + b + cin
//   cout  out carry out (bit 8 of the 9-bit result)
module oiia_add8
    import oiia_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] full;

    assign full        = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
    assign {cout, sum} = full;

endmodule

// File: rtl/oiia_add_seq.sv
// oiia_add_seq: multi-byte add/subtract sequencer around a single shared 8-bit adder.
// Operands A then B arrive LSB first on a valid/ready byte stream, are combined one byte
// per cycle with the carry held in a register, and the result leaves LSB first on a
// valid/ready byte stream.
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   synchronous abort back to IDLE (wins over any handshake)
//   in_valid/in_ready     input byte handshake; in_data is the byte, in_sub picks A-B
//   out_valid/out_ready   result byte handshake; out_data is the byte
//   out_last, out_carry   final-byte marker and final carry (1 = no borrow on subtract)
//   busy                  sequencer is not idle
module oiia_add_seq
    import oiia_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              out_carry,
    output logic              busy
);

    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          carry_q, carry_d;
    logic                          sub_q, sub_d;
    logic [NBYTES-1:0][BYTE_W-1:0] a_q, a_d;
    logic [NBYTES-1:0][BYTE_W-1:0] b_q, b_d;

    logic [BYTE_W-1:0] add_a, add_b, add_sum;
    logic              add_cout;
    logic              at_last;
    logic              in_hs, out_hs;

    // Handshake qualifiers are decoded from state only, so no input-to-ready paths exist.
    assign in_ready  = (state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B);
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign at_last   = (idx_q == LAST_IDX);

    // Outputs are forced to zero outside EMIT so the idle/reset values are clean.
    assign out_data  = out_valid ? a_q[idx_q] : '0;
    assign out_last  = out_valid && at_last;
    assign out_carry = out_last && carry_q;

    // Subtract is A + ~B + 1; the +1 comes from carry being seeded with sub.
    assign add_a = a_q[idx_q];
    assign add_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];

    oiia_add8 u_add8 (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;

        if (clr) begin
            state_d = IDLE;
            idx_d   = '0;
            carry_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        a_d[0] = in_data;
                        sub_d  = in_sub;
                        // A single-byte operand skips straight to loading B.
                        if (NBYTES == 1) begin
                            state_d = LOAD_B;
                            idx_d   = '0;
                        end else begin
                            state_d = LOAD_A;
                            idx_d   = IDX_W'(1);
                        end
                    end
                end
                LOAD_A: begin
                    if (in_hs) begin
                        a_d[idx_q] = in_data;
                        if (at_last) begin
                            state_d = LOAD_B;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (in_hs) begin
                        b_d[idx_q] = in_data;
                        if (at_last) begin
                            state_d = ADD;
                            idx_d   = '0;
                            carry_d = sub_q;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ADD: begin
                    a_d[idx_q] = add_sum;
                    carry_d    = add_cout;
                    if (at_last) begin
                        state_d = EMIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (at_last) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: tb/tb_oiia_add_seq.sv
// tb_oiia_add_seq: directed self-checking bench for oiia_add_seq.
// Instantiates a 4-byte sequencer and a 1-byte sequencer; each scenario task drives its
// own stimulus and compares against hand-computed values.
module tb_oiia_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr, in_valid, in_sub, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, out_last, out_carry, busy;
    logic [7:0] out_data;

    logic       clr_1, in_valid_1, in_sub_1, out_ready_1;
    logic [7:0] in_data_1;
    logic       in_ready_1, out_valid_1, out_last_1, out_carry_1, busy_1;
    logic [7:0] out_data_1;

    int checks = 0;
    int errors = 0;

    oiia_add_seq #(.NBYTES(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_carry (out_carry),
        .busy      (busy)
    );

    oiia_add_seq #(.NBYTES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_1),
        .in_valid  (in_valid_1),
        .in_ready  (in_ready_1),
        .in_data   (in_data_1),
        .in_sub    (in_sub_1),
        .out_valid (out_valid_1),
        .out_ready (out_ready_1),
        .out_data  (out_data_1),
        .out_last  (out_last_1),
        .out_carry (out_carry_1),
        .busy      (busy_1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams 4 bytes of A then 4 bytes of B; returns 1 in to if in_ready never came.
    // Returns #1 after the edge that accepted the last B byte.
    task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output bit to);
        int n;
        to = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = (i < 4) ? a[8*i +: 8] : b[8*(i-4) +: 8];
            in_sub   = sub;
            n = 0;
            while (!in_ready && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) to = 1'b1;
            step();
        end
        in_valid = 1'b0;
        in_sub   = 1'b0;
    endtask

    // Collects 4 result bytes; lat is the number of edges waited before out_valid.
    task automatic recv4(output logic [31:0] data, output logic [3:0] lasts,
                         output logic [3:0] carries, output int lat, output bit to);
        int n;
        to = 1'b0;
        n  = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        lat = n;
        if (n >= 50) to = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!out_valid && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) to = 1'b1;
            data[8*i +: 8] = out_data;
            lasts[i]       = out_last;
            carries[i]     = out_carry;
            out_ready      = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl4: got rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (out_data !== 8'h00 || out_last !== 1'b0 || out_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_data4: got data=%h last=%b carry=%b want 00 0 0",
                     out_data, out_last, out_carry);
        end
        checks++;
        if (in_ready_1 !== 1'b1 || out_valid_1 !== 1'b0 || busy_1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl1: got rdy=%b vld=%b busy=%b want 1 0 0",
                     in_ready_1, out_valid_1, busy_1);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        logic [31:0] d;
        logic [3:0]  l, c;
        int          lat;
        bit          to1, to2;
        send4(32'h0000_00FF, 32'h0000_0001, 1'b0, to1);
        recv4(d, l, c, lat, to2);
        checks++;
        if (to1 || to2) begin
            errors++;
            $display("FAIL add_timeout: got timeout in=%b out=%b want 0 0", to1, to2);
        end
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++;
            $display("FAIL add_data: got %h want 00000100", d);
        end
        checks++;
        if (l !== 4'b1000 || c !== 4'b0000) begin
            errors++;
            $display("FAIL add_flags: got last=%b carry=%b want 1000 0000", l, c);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [3:0]  l, c;
        int          lat;
        bit          to1, to2;
        send4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, to1);
        recv4(d, l, c, lat, to2);
        checks++;
        if (to1 || to2 || d !== 32'h0000_0000) begin
            errors++;
            $display("FAIL ovf_data: got %h to=%b%b want 00000000", d, to1, to2);
        end
        checks++;
        if (c !== 4'b1000 || l !== 4'b1000) begin
            errors++;
            $display("FAIL ovf_flags: got carry=%b last=%b want 1000 1000", c, l);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL ovf_latency: got %0d edges want 4", lat);
        end
    endtask

    task automatic test_sub();
        logic [31:0] d;
        logic [3:0]  l, c;
        int          lat;
        bit          to1, to2;
        send4(32'd5, 32'd7, 1'b1, to1);
        recv4(d, l, c, lat, to2);
        checks++;
        if (to1 || to2 || d !== 32'hFFFF_FFFE || c !== 4'b0000) begin
            errors++;
            $display("FAIL sub_5m7: got %h carry=%b want fffffffe 0000", d, c);
        end
        send4(32'd7, 32'd5, 1'b1, to1);
        recv4(d, l, c, lat, to2);
        checks++;
        if (to1 || to2 || d !== 32'h0000_0002 || c !== 4'b1000) begin
            errors++;
            $display("FAIL sub_7m5: got %h carry=%b want 00000002 1000", d, c);
        end
    endtask

    task automatic test_backpressure();
        bit          to;
        bit          rdy_seen;
        bit          stable;
        int          n;
        logic [23:0] rest;
        logic [2:0]  lasts;
        send4(32'h0000_00FF, 32'h0000_0001, 1'b0, to);
        rdy_seen = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            n++;
        end
        checks++;
        if (to || n >= 50) begin
            errors++;
            $display("FAIL bp_timeout: got wait=%0d to=%b want valid within 50", n, to);
        end
        // consume byte 0, then stall on byte 1
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (out_data !== 8'h01 || out_valid !== 1'b1 || out_last !== 1'b0) stable = 1'b0;
            if (in_ready) rdy_seen = 1'b1;
            step();
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_stable: got data=%h vld=%b want 01 held valid", out_data,
                     out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready) rdy_seen = 1'b1;
            rest[8*i +: 8] = out_data;
            lasts[i]       = out_last;
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (rest !== 24'h00_0001 || lasts !== 3'b100) begin
            errors++;
            $display("FAIL bp_bytes: got %h last=%b want 000001 100", rest, lasts);
        end
        checks++;
        if (rdy_seen) begin
            errors++;
            $display("FAIL bp_in_ready: got in_ready=1 during ADD/EMIT want 0");
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_clr();
        logic [31:0] d;
        logic [3:0]  l, c;
        int          lat;
        bit          to1, to2;
        // A plus two bytes of B, then abort with a byte on the bus
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h33;
            step();
        end
        clr     = 1'b1;
        in_data = 8'h44;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_idle: got busy=%b rdy=%b want 0 1", busy, in_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_drop: got busy=%b after clr want 0", busy);
        end
        send4(32'h1234_5678, 32'h1111_1111, 1'b0, to1);
        recv4(d, l, c, lat, to2);
        checks++;
        if (to1 || to2 || d !== 32'h2345_6789 || c !== 4'b0000 || l !== 4'b1000) begin
            errors++;
            $display("FAIL clr_after: got %h carry=%b last=%b want 23456789 0000 1000",
                     d, c, l);
        end
    endtask

    task automatic test_rst_mid_add();
        logic [31:0] d;
        logic [3:0]  l, c;
        int          lat;
        bit          to1, to2;
        send4(32'h0000_0001, 32'h0000_0002, 1'b0, to1);
        step();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: got busy=%b vld=%b want 1 0 mid-ADD", busy, out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_data !== 8'h00 || out_last !== 1'b0 || out_carry !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got busy=%b rdy=%b vld=%b data=%h last=%b carry=%b want 0 1 0 00 0 0",
                     busy, in_ready, out_valid, out_data, out_last, out_carry);
        end
        step();
        rst_n = 1'b1;
        step();
        send4(32'h0000_0100, 32'h0000_0001, 1'b1, to1);
        recv4(d, l, c, lat, to2);
        checks++;
        if (to1 || to2 || d !== 32'h0000_00FF || c !== 4'b1000) begin
            errors++;
            $display("FAIL rst_after: got %h carry=%b want 000000ff 1000", d, c);
        end
    endtask

    task automatic test_nbytes1();
        int n;
        in_valid_1 = 1'b1;
        in_data_1  = 8'h80;
        step();
        step();
        in_valid_1 = 1'b0;
        n = 0;
        while (!out_valid_1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL n1_latency: got %0d edges want 1", n);
        end
        checks++;
        if (out_valid_1 !== 1'b1 || out_data_1 !== 8'h00 || out_last_1 !== 1'b1 ||
            out_carry_1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_result: got vld=%b data=%h last=%b carry=%b want 1 00 1 1",
                     out_valid_1, out_data_1, out_last_1, out_carry_1);
        end
        out_ready_1 = 1'b1;
        step();
        out_ready_1 = 1'b0;
        checks++;
        if (busy_1 !== 1'b0 || out_valid_1 !== 1'b0) begin
            errors++;
            $display("FAIL n1_idle: got busy=%b vld=%b want 0 0", busy_1, out_valid_1);
        end
    endtask

    initial begin
        clr         = 1'b0;
        in_valid    = 1'b0;
        in_sub      = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        clr_1       = 1'b0;
        in_valid_1  = 1'b0;
        in_sub_1    = 1'b0;
        in_data_1   = 8'h00;
        out_ready_1 = 1'b0;
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_backpressure();
        test_clr();
        test_rst_mid_add();
        test_nbytes1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
